// File: rtl/serial_subtractor_nbit.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_nbit
// Description : Bit-serial N-bit subtractor with a start/done handshake.
//               Computes (a - b - borrow_in) one bit per clock, LSB first,
//               trading latency for area.
//
// Ports       : clk         - system clock, rising edge
//               n_rst       - asynchronous active-low reset
//               start       - request, sampled only while idle
//               a, b        - minuend / subtrahend, captured on accept
//               borrow_in   - initial borrow, captured on accept
//               busy        - high while an operation is in flight
//               done        - one-cycle pulse, result valid
//               difference  - (a - b - borrow_in) mod 2^NUM_BITS, registered
//               underflow   - final borrow out (a < b + borrow_in), registered
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] difference,
    output logic                underflow
);

    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUM_BITS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic [NUM_BITS-1:0] r_a_sr;
    logic [NUM_BITS-1:0] r_b_sr;
    // Holds only the upper NUM_BITS-1 result bits: the oldest bit would be
    // shifted out on the same edge the result is committed, so it is never
    // stored.
    logic [NUM_BITS-2:0] r_res_sr;
    logic                r_brw;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_difference;
    logic                r_underflow;

    logic                w_d;
    logic                w_brw_next;
    logic [NUM_BITS-1:0] w_res_next;
    logic                w_last;

    // ------------------------------------------------------------------
    // Full-subtractor slice on the current LSBs
    // ------------------------------------------------------------------
    assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
    assign w_brw_next = (~r_a_sr[0] & r_b_sr[0]) |
                        (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);
    assign w_res_next = {w_d, r_res_sr};
    assign w_last     = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: if (start)  w_state_next = c_calc;
            c_calc: if (w_last) w_state_next = c_done;
            c_done:             w_state_next = c_idle;
            default:            w_state_next = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_calc: busy = 1'b1;
            c_done: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, bit-serial subtraction, result commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_brw        <= 1'b0;
            r_cnt        <= '0;
            r_difference <= '0;
            r_underflow  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_brw  <= borrow_in;
                        r_cnt  <= '0;
                    end
                end
                c_calc: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_brw    <= w_brw_next;
                    r_res_sr <= w_res_next[NUM_BITS-1:1];
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Result registers change only here, so they hold
                    // across any later start until the next completion.
                    if (w_last) begin
                        r_difference <= w_res_next;
                        r_underflow  <= w_brw_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign difference = r_difference;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire
